// File: rtl/jt7759_datafifo.sv
// Sample-data FIFO for jt7759: ROM prefetch in master mode, CPU write capture in slave mode.
// Optional `JT7759_DATAFIFO_STATS_EN adds the ovf_cnt drop/underrun counter output.
module jt7759_datafifo #(
  parameter int DW = 8,
  parameter int AW = 17,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen_ctl,
  input  logic          mdn,
  input  logic          ctrl_busyn,
  input  logic          ctrl_load,
  input  logic [AW-1:0] ctrl_addr,
  input  logic          ctrl_cs,
  output logic [DW-1:0] ctrl_din,
  output logic          ctrl_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  input  logic          cs,
  input  logic          wrn,
  input  logic [DW-1:0] din,
  output logic          drqn,
  output logic [LW:0]   level,
  output logic          ovf
`ifdef JT7759_DATAFIFO_STATS_EN
  ,
  output logic [7:0]    ovf_cnt
`endif
);

  localparam int DEPTH = 1 << LW;
  localparam logic [LW:0] FULL = (LW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rom_data_p0;
  logic          wr_q, ctrl_cs_q, armed;
  logic          wr_stb, wr_rise, cs_rise;
  logic          slv_wr, rom_push, has_room, has_data;
  logic          push, pop;
  logic [DW-1:0] push_data;

  assign wr_stb    = cs & ~wrn;
  assign wr_rise   = wr_stb & ~wr_q;
  assign cs_rise   = ctrl_cs & ~ctrl_cs_q;
  assign has_room  = level < FULL;
  assign has_data  = level != '0;
  assign slv_wr    = ~mdn & ~ctrl_busyn & wr_rise;
  assign rom_push  = (state == PUSH) & ~ctrl_busyn;
  assign push      = (slv_wr | rom_push) & has_room;
  assign pop       = armed & has_data & ~ctrl_busyn;
  assign push_data = mdn ? rom_data_p0 : din;
  assign rom_cs    = state != IDLE;

  // Only IDLE->REQ waits for cen_ctl; the ROM ack and the push slot run at full clock rate
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cen_ctl && mdn && !ctrl_busyn && has_room) state_nx = REQ;
      REQ:     if (rom_ok) state_nx = PUSH;
      PUSH:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ctrl_busyn) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rom_addr  <= '0;
      drqn      <= 1'b1;
      ovf       <= 1'b0;
      armed     <= 1'b0;
      ctrl_ok   <= 1'b0;
      ctrl_din  <= '0;
      wr_q      <= 1'b0;
      ctrl_cs_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_q      <= wr_stb;
      ctrl_cs_q <= ctrl_cs;
      if (ctrl_busyn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        drqn   <= 1'b1;
        ovf    <= 1'b0;
        if (ctrl_load) rom_addr <= ctrl_addr;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
        if (slv_wr && !has_room) ovf <= 1'b1;
        if (cen_ctl) drqn <= ~has_room;
        if (rom_push) rom_addr <= rom_addr + 1'b1;
      end
      if (!ctrl_cs)  ctrl_ok <= 1'b0;
      else if (pop)  ctrl_ok <= 1'b1;
      if (!ctrl_cs || ctrl_busyn || pop) armed <= 1'b0;
      else if (cs_rise)                  armed <= 1'b1;
      if (pop) ctrl_din <= mem[rd_ptr];
    end
  end

  // Data storage: ROM byte captured on ack, written into the FIFO on the PUSH cycle
  always_ff @(posedge clk) begin
    if (state == REQ && rom_ok) rom_data_p0 <= rom_data;
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef JT7759_DATAFIFO_STATS_EN
  logic [8:0] und_cnt;

  // An armed read starved for 256 cycles counts once, then und_cnt parks at 256
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
      und_cnt <= '0;
    end else if (ctrl_busyn) begin
      ovf_cnt <= '0;
      und_cnt <= '0;
    end else begin
      if (armed && !has_data) begin
        if (und_cnt != 9'd256) und_cnt <= und_cnt + 1'b1;
      end else begin
        und_cnt <= '0;
      end
      if (((slv_wr && !has_room) || (armed && !has_data && und_cnt == 9'd255))
          && ovf_cnt != 8'hFF)
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule
